id_ex_operand_stage: RTL

//  ID/EX pipeline register and operand-select stage directly upstream of the EX-stage ALU.

---
 rtl/id_ex_operand_stage.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/id_ex_operand_stage.sv
// id_ex_operand_stage
//   ID/EX pipeline register and operand-select stage feeding the EX-stage ALU.
//   Captures decoded operands/control, forwards EX/MEM and MEM/WB results onto
//   the ALU operands, detects load-use hazards (inserting one bubble) and
//   drives registered ALU funct/sign.
//
// Ports
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   stall, flush        hold stage / load a bubble on next edge
//   id_*                decoded instruction fields from ID
//   exmem_*, memwb_*    forwarding sources (reg_write, rd, result)
//   alu_in1/alu_in2     forwarded ALU operands (combinational from stage regs)
//   alu_funct/alu_sign  registered ALU control
//   ex_valid, ex_rd, ex_reg_write, ex_mem_read  registered control
//   ex_store_data       forwarded rt value for stores
//   load_use_hazard     combinational; upstream stalls IF/ID while high
//   bubble_count        bubbles loaded, saturating (only with ID_EX_PERF_EN)
//
// Configuration
//   ID_EX_PERF_EN       when defined, adds the bubble_count output and counter.

// Forwarding select for one source operand. EX/MEM is younger than MEM/WB so
// it wins; register 0 is hardwired and never forwarded.
module id_ex_fwd_mux #(
  parameter int DW = 32,
  parameter int RA = 5
) (
  input  logic [RA-1:0] addr,
  input  logic [DW-1:0] reg_data,
  input  logic          exmem_reg_write,
  input  logic [RA-1:0] exmem_rd,
  input  logic [DW-1:0] exmem_result,
  input  logic          memwb_reg_write,
  input  logic [RA-1:0] memwb_rd,
  input  logic [DW-1:0] memwb_result,
  output logic [DW-1:0] fwd
);
  logic exmem_hit, memwb_hit;

  assign exmem_hit = exmem_reg_write && (exmem_rd != '0) && (exmem_rd == addr);
  assign memwb_hit = memwb_reg_write && (memwb_rd != '0) && (memwb_rd == addr);

  always_comb begin
    fwd = reg_data;
    if (exmem_hit)      fwd = exmem_result;
    else if (memwb_hit) fwd = memwb_result;
  end
endmodule

module id_ex_operand_stage #(
  parameter int DW = 32,
  parameter int RA = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          stall,
  input  logic          flush,
  input  logic          id_valid,
  input  logic [RA-1:0] id_rs_addr,
  input  logic [RA-1:0] id_rt_addr,
  input  logic [DW-1:0] id_rs_data,
  input  logic [DW-1:0] id_rt_data,
  input  logic [DW-1:0] id_imm,
  input  logic [4:0]    id_shamt,
  input  logic          id_alu_src_imm,
  input  logic          id_use_shamt,
  input  logic [5:0]    id_funct,
  input  logic          id_sign,
  input  logic [RA-1:0] id_rd_addr,
  input  logic          id_reg_write,
  input  logic          id_mem_read,
  input  logic          exmem_reg_write,
  input  logic [RA-1:0] exmem_rd,
  input  logic [DW-1:0] exmem_result,
  input  logic          memwb_reg_write,
  input  logic [RA-1:0] memwb_rd,
  input  logic [DW-1:0] memwb_result,
  output logic [DW-1:0] alu_in1,
  output logic [DW-1:0] alu_in2,
  output logic [5:0]    alu_funct,
  output logic          alu_sign,
  output logic          ex_valid,
  output logic [RA-1:0] ex_rd,
  output logic          ex_reg_write,
  output logic          ex_mem_read,
  output logic [DW-1:0] ex_store_data,
  output logic          load_use_hazard
`ifdef ID_EX_PERF_EN
  ,
  output logic [31:0]   bubble_count
`endif
);
  localparam int NSRC = 2;  // 0: rs, 1: rt

  typedef struct packed {
    logic          valid;
    logic [RA-1:0] rs_addr;
    logic [RA-1:0] rt_addr;
    logic [DW-1:0] rs_data;
    logic [DW-1:0] rt_data;
    logic [DW-1:0] imm;
    logic [4:0]    shamt;
    logic          alu_src_imm;
    logic          use_shamt;
    logic [5:0]    funct;
    logic          sign;
    logic [RA-1:0] rd;
    logic          reg_write;
    logic          mem_read;
  } stage_t;

  stage_t id_d, ex_q;
  logic   load_bubble;

  logic [NSRC-1:0][RA-1:0] src_addr;
  logic [NSRC-1:0][DW-1:0] src_data;
  logic [NSRC-1:0][DW-1:0] src_fwd;

  always_comb begin
    id_d             = '0;
    id_d.valid       = id_valid;
    id_d.rs_addr     = id_rs_addr;
    id_d.rt_addr     = id_rt_addr;
    id_d.rs_data     = id_rs_data;
    id_d.rt_data     = id_rt_data;
    id_d.imm         = id_imm;
    id_d.shamt       = id_shamt;
    id_d.alu_src_imm = id_alu_src_imm;
    id_d.use_shamt   = id_use_shamt;
    id_d.funct       = id_funct;
    id_d.sign        = id_sign;
    id_d.rd          = id_rd_addr;
    id_d.reg_write   = id_reg_write;
    id_d.mem_read    = id_mem_read;
  end

  // An immediate-form instruction does not read rt, so it cannot collide on rt.
  assign load_use_hazard = ex_q.valid && ex_q.mem_read && (ex_q.rd != '0) && id_valid &&
                           ((ex_q.rd == id_rs_addr) ||
                            ((ex_q.rd == id_rt_addr) && !id_alu_src_imm));

  assign load_bubble = flush || load_use_hazard;

  // Bubble is all-zero; it outranks stall so a hazard always drains.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)            ex_q <= '0;
    else if (load_bubble) ex_q <= '0;
    else if (!stall)      ex_q <= id_d;
  end

  assign src_addr[0] = ex_q.rs_addr;
  assign src_addr[1] = ex_q.rt_addr;
  assign src_data[0] = ex_q.rs_data;
  assign src_data[1] = ex_q.rt_data;

  for (genvar g = 0; g < NSRC; g++) begin : g_fwd
    id_ex_fwd_mux #(.DW(DW), .RA(RA)) u_fwd (
      .addr            (src_addr[g]),
      .reg_data        (src_data[g]),
      .exmem_reg_write (exmem_reg_write),
      .exmem_rd        (exmem_rd),
      .exmem_result    (exmem_result),
      .memwb_reg_write (memwb_reg_write),
      .memwb_rd        (memwb_rd),
      .memwb_result    (memwb_result),
      .fwd             (src_fwd[g])
    );
  end

  assign alu_in1       = ex_q.use_shamt   ? {{(DW-5){1'b0}}, ex_q.shamt} : src_fwd[0];
  assign alu_in2       = ex_q.alu_src_imm ? ex_q.imm : src_fwd[1];
  assign ex_store_data = src_fwd[1];
  assign alu_funct     = ex_q.funct;
  assign alu_sign      = ex_q.sign;
  assign ex_valid      = ex_q.valid;
  assign ex_rd         = ex_q.rd;
  assign ex_reg_write  = ex_q.reg_write;
  assign ex_mem_read   = ex_q.mem_read;

`ifdef ID_EX_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                     bubble_count <= '0;
    else if (load_bubble && (bubble_count != '1))  bubble_count <= bubble_count + 32'd1;
  end
`endif
endmodule
